// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one 32-bit memory port between instruction fetch (IF)
//               and load/store (LS). LS has fixed priority, and a starvation
//               guard forces an IF grant after STARVE_LIMIT contested LS wins.
//               Optional BUSY timeout abort: define ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              mem_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              arb_err
);

  localparam int c_STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_owner;
  logic [c_STARVE_W-1:0] r_starve_cnt;

  logic w_contested;
  logic w_starve_ok;
  logic w_ls_wins;

  // LS wins when alone, or when contested and IF has not yet lost too often.
  assign w_contested = if_req & ls_req;
  assign w_starve_ok = (32'(r_starve_cnt) < 32'(STARVE_LIMIT));
  assign w_ls_wins   = ls_req & (~if_req | w_starve_ok);

`ifdef ARB_TIMEOUT_EN
  localparam int c_TIMEOUT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [c_TIMEOUT_W-1:0] r_busy_cnt;
  logic                   r_arb_err;
  logic                   w_timeout;

  // Fires on the TIMEOUT_CYC-th BUSY cycle counted from entry.
  assign w_timeout = ((32'(r_busy_cnt) + 32'd1) >= 32'(TIMEOUT_CYC));
  assign arb_err   = r_arb_err;
`else
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_sel      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_done      <= 1'b0;
      ls_done      <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
`ifdef ARB_TIMEOUT_EN
      r_busy_cnt   <= '0;
      r_arb_err    <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_arb_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (if_req || ls_req) begin
            r_state <= ST_BUSY;
            mem_req <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_busy_cnt <= '0;
`endif
            if (w_ls_wins) begin
              r_owner   <= 1'b1;
              mem_sel   <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              if (w_contested && w_starve_ok)
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
              r_owner      <= 1'b0;
              mem_sel      <= 1'b0;
              mem_we       <= 1'b0;
              mem_addr     <= if_addr;
              mem_wdata    <= '0;
              r_starve_cnt <= '0;
            end
          end
        end

        ST_BUSY: begin
          if (mem_ack) begin
            r_state <= ST_RESP;
            mem_req <= 1'b0;
            if (r_owner) begin
              ls_done <= 1'b1;
              if (!mem_we)
                ls_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_state   <= ST_RESP;
            mem_req   <= 1'b0;
            r_arb_err <= 1'b1;
            if (r_owner) begin
              ls_done  <= 1'b1;
              ls_rdata <= '0;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          // Requests are deliberately not sampled here.
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mem_sel;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        arb_err;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYC (16)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_done  (ls_done),
    .ls_rdata (ls_rdata),
    .mem_sel  (mem_sel),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .arb_err  (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_sel [10];

  initial begin
    exp_sel = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_sel", mem_sel, 1'b0);
    chk("rst_if_done", if_done, 1'b0);
    chk("rst_ls_done", ls_done, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_arb_err", arb_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // IF fetch with ack one cycle after mem_req
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    chk("if_mem_req", mem_req, 1'b1);
    chk("if_mem_sel", mem_sel, 1'b0);
    chk("if_mem_addr", mem_addr, 32'h0000_0040);
    chk("if_mem_we", mem_we, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 1'b0;
    chk("if_done", if_done, 1'b1);
    chk("if_rdata", if_rdata, 32'h0000_0013);
    chk("if_resp_mem_req", mem_req, 1'b0);
    chk("if_resp_ls_done", ls_done, 1'b0);
    if_req = 1'b0;
    tick();
    chk("if_done_pulse", if_done, 1'b0);

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_if_done", if_done, 1'b0);
    chk("idle_ack_ls_done", ls_done, 1'b0);
    chk("idle_ack_if_rdata", if_rdata, 32'h0000_0013);
    chk("idle_ack_mem_req", mem_req, 1'b0);

    // LS store, ack delayed by a cycle
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_1000; ls_wdata = 32'hCAFE_F00D;
    tick();
    chk("st_mem_sel", mem_sel, 1'b1);
    chk("st_mem_we", mem_we, 1'b1);
    chk("st_mem_addr", mem_addr, 32'h0000_1000);
    chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    tick();
    chk("st_wait_mem_req", mem_req, 1'b1);
    chk("st_wait_ls_done", ls_done, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("st_ls_done", ls_done, 1'b1);
    chk("st_ls_rdata", ls_rdata, 32'h0);
    ls_req = 1'b0;
    tick();

    // LS load
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_2000;
    tick();
    chk("ld_mem_we", mem_we, 1'b0);
    chk("ld_mem_sel", mem_sel, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_55AA;
    tick();
    mem_ack = 1'b0;
    chk("ld_ls_done", ls_done, 1'b1);
    chk("ld_ls_rdata", ls_rdata, 32'h0000_55AA);
    chk("ld_if_rdata_hold", if_rdata, 32'h0000_0013);
    ls_req = 1'b0;
    tick();

    // Both held: LS x4, IF, LS x4, IF
    if_req = 1'b1; if_addr = 32'h0000_0040;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_3000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("starve_sel_%0d", i), mem_sel, exp_sel[i]);
      chk($sformatf("starve_req_%0d", i), mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h100 + i;
      tick();
      mem_ack = 1'b0;
      chk($sformatf("starve_done_%0d", i), exp_sel[i] ? ls_done : if_done, 1'b1);
      if (i == 9) begin
        if_req = 1'b0; ls_req = 1'b0;
      end
      tick();
    end
    chk("starve_if_rdata", if_rdata, 32'h109);
    chk("starve_ls_rdata", ls_rdata, 32'h108);

    // Reset while BUSY, late ack ignored
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_4000; ls_wdata = 32'h1111_2222;
    tick();
    chk("rb_mem_req", mem_req, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ls_req = 1'b0;
    chk("rb_mem_req0", mem_req, 1'b0);
    chk("rb_mem_sel0", mem_sel, 1'b0);
    chk("rb_mem_we0", mem_we, 1'b0);
    chk("rb_mem_addr0", mem_addr, 32'h0);
    chk("rb_mem_wdata0", mem_wdata, 32'h0);
    chk("rb_if_rdata0", if_rdata, 32'h0);
    chk("rb_ls_rdata0", ls_rdata, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("rb_late_ls_done", ls_done, 1'b0);
    chk("rb_late_if_done", if_done, 1'b0);
    chk("rb_late_ls_rdata", ls_rdata, 32'h0);
    chk("rb_late_mem_req", mem_req, 1'b0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // No ack: abort on the 16th BUSY cycle
    if_req = 1'b1; if_addr = 32'h0000_0080;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_00AB;
    tick();
    mem_ack = 1'b0;
    if_req = 1'b0;
    tick();
    chk("to_pre_if_rdata", if_rdata, 32'hAB);
    if_req = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("to_busy_mem_req", mem_req, 1'b1);
      chk("to_busy_if_done", if_done, 1'b0);
    end
    tick();
    chk("to_if_done", if_done, 1'b1);
    chk("to_arb_err", arb_err, 1'b1);
    chk("to_if_rdata", if_rdata, 32'h0);
    chk("to_mem_req", mem_req, 1'b0);
    if_req = 1'b0;
    tick();
    chk("to_arb_err_pulse", arb_err, 1'b0);
    tick();
    chk("to_idle_mem_req", mem_req, 1'b0);

    // Ack on the timeout cycle completes normally
    if_req = 1'b1; if_addr = 32'h0000_0084;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("tb_busy_mem_req", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 1'b0;
    chk("tb_if_done", if_done, 1'b1);
    chk("tb_arb_err", arb_err, 1'b0);
    chk("tb_if_rdata", if_rdata, 32'h0000_0077);
    if_req = 1'b0;
    tick();
`else
    // No ack: BUSY holds with mem_req high indefinitely
    if_req = 1'b1; if_addr = 32'h0000_0080;
    tick();
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("nt_mem_req", mem_req, 1'b1);
      chk("nt_if_done", if_done, 1'b0);
      chk("nt_arb_err", arb_err, 1'b0);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
    tick();
    mem_ack = 1'b0;
    chk("nt_if_done_final", if_done, 1'b1);
    chk("nt_if_rdata", if_rdata, 32'h0000_0099);
    chk("nt_arb_err_final", arb_err, 1'b0);
    if_req = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared 32-bit memory port between the instruction-fetch path (IF) and the load/store path (LS). This is the first step in moving the core off separate instruction and data memories.
- Drives the 2:1 address/data select for the shared port. Sequences each access through request, memory acknowledge and a one-cycle response.
- Fixed LS priority, with a starvation guard that forces an IF grant after a bounded number of losses.

Parameters:
ADDR_W, 32, width of requester and memory addresses
STARVE_LIMIT, 4, consecutive contested LS wins before IF is forced; 0 = IF always wins when contested
TIMEOUT_CYC, 16, cycles in BUSY without mem_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  IF request; held with if_addr stable until if_done
if_addr  in  ADDR_W  IF fetch address
if_done  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  32  fetched word
ls_req  in  1  LS request; held with ls_we/ls_addr/ls_wdata stable until ls_done
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  LS address
ls_wdata  in  32  store data
ls_done  out  1  one-cycle pulse, ls_rdata valid (loads)
ls_rdata  out  32  load data
mem_sel  out  1  shared-port mux select: 0 = IF, 1 = LS
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid when mem_ack = 1
mem_ack  in  1  memory completion, single-cycle pulse
arb_err  out  1  one-cycle pulse with done on timeout abort; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- State machine has three states: IDLE, BUSY, RESP. An owner register (0 = IF, 1 = LS) is captured on grant.
- Reset (rst_n = 0 at an edge, in any state, including mid-access):
  - State goes to IDLE; owner = 0; starve counter = 0.
  - All outputs go to 0: mem_req, mem_we, mem_sel, mem_addr, mem_wdata, both done signals, both rdata outputs, arb_err.
  - An in-flight access is abandoned. A later mem_ack is ignored.
- IDLE:
  - No request: stay in IDLE; mem_req = 0.
  - Only one request: grant that port.
  - Both requesting: grant LS if starve_cnt < STARVE_LIMIT, else grant IF.
  - On grant: owner is registered, and mem_sel/mem_addr/mem_we/mem_wdata are registered from the winner. mem_we and mem_wdata are 0 for IF. Next state is BUSY.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each contested decision that LS wins.
  - Clears on any IF grant.
  - Unchanged on uncontested LS grants.
- BUSY:
  - mem_req = 1; memory fields held stable.
  - mem_ack = 1: mem_rdata is registered into the owner's rdata output, the owner's done is set for the next cycle, and the state goes to RESP.
  - mem_ack = 0: stay in BUSY.
- RESP (exactly one cycle):
  - Owner's done = 1; mem_req = 0.
  - Requests are not sampled. The requester must drop req in this cycle or it is treated as a new request in IDLE.
  - Next state is IDLE.
- Latency: a request seen in IDLE at cycle N gives mem_req at N+1. With mem_ack at N+1, done is at N+2 and the next grant decision is at N+3. Throughput is 1 access per 3 cycles at best.
- rdata holds its last value until the next completion for that port. Store completions leave ls_rdata unchanged.
- mem_ack outside BUSY is ignored.
- Address and data pass through unmodified at ADDR_W/32 bits; there is no alignment checking.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A BUSY cycle counter clears on entry to BUSY.
  - If the count reaches TIMEOUT_CYC with no mem_ack, the state goes to RESP. The owner's done and arb_err pulse together, and the owner's rdata is loaded with 32'h0000_0000.
  - mem_ack in the same cycle as the timeout wins as a normal completion (arb_err = 0).
- Undefined: no counter; BUSY waits indefinitely; arb_err is tied to 0.

Test Plan:
- Reset, then if_req = 1 with if_addr = 0x0000_0040 and mem_ack one cycle after mem_req with mem_rdata = 0x0000_0013 -> mem_sel = 0, mem_req at N+1, if_done at N+2 with if_rdata = 0x0000_0013.
- ls_req = 1, ls_we = 1, ls_addr = 0x0000_1000, ls_wdata = 0xCAFE_F00D -> mem_sel = 1, mem_we = 1 and mem_wdata = 0xCAFE_F00D while mem_req = 1; ls_done pulse; ls_rdata unchanged.
- Both requests held continuously with STARVE_LIMIT = 4 -> grant order LS, LS, LS, LS, IF, LS…; starve counter returns to 0 after the IF grant.
- rst_n low for one edge while in BUSY, then mem_ack pulses afterward -> all outputs 0 the next cycle; no done pulses; the late ack is ignored.
- ARB_TIMEOUT_EN with TIMEOUT_CYC = 16 and mem_ack never asserted -> done and arb_err pulse together 16 cycles after BUSY entry, rdata = 0, back to IDLE; without the macro, mem_req stays high indefinitely.
- mem_ack arriving on exactly the TIMEOUT_CYC cycle -> normal completion with mem_rdata returned; arb_err = 0.
